recv_serial: RTL and testbench

//   UART receiver (8N1, LSB first, idle-high line): the receive-side counterpart of send_serial.

---
 rtl/serial_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/recv_serial.sv | 154 +++++++++++++++
 tb/tb_recv_serial.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-timing helper
// used by both send_serial and recv_serial so the two ends agree on timing.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; RST_VAL sets the
// value both flops take in reset (1 for an idle-high serial line).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/recv_serial.sv
// UART receiver, 8N1 LSB first, idle-high line, mid-bit sampling.
// Define RECV_SERIAL_PARITY_EN for an 8E1/8O1 frame (PARITY_ODD selects odd).
module recv_serial
  import serial_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

`ifdef RECV_SERIAL_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             par_ok;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_in),
    .q   (rx_s)
  );

  assign par_ok = (((^shreg_q) ^ PARITY_ODD) == par_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // Decided at the stop-bit centre so the next start edge lands in IDLE.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else if (!PARITY_EN || par_ok) begin
            data_out_d = shreg_q;
            valid_d    = 1'b1;
            state_d    = IDLE;
          end else begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_recv_serial.sv
// Self-checking bench for recv_serial: directed frames plus random traffic,
// scored against a queue of expected receive events built from the frames sent.
module tb_recv_serial;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = CPB / 2;
  localparam bit          PODD     = 1'b0;
`ifdef RECV_SERIAL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int unsigned LAT = 2 + HALF + 9 * CPB + (PAR_EN ? CPB : 0);

  localparam int EV_VALID = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_PARITY = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, parity_err, busy;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_valid = 0, n_frame = 0, n_parity = 0;
  int   cyc = 0;
  int   valid_cyc = 0;
  ev_t  exp_q[$];
  logic [7:0] last_good = 8'h00;

  recv_serial #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .PARITY_ODD(PODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every pulse must match the oldest outstanding expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (!rst && (valid || frame_err || parity_err)) begin
      check_eq("pulse_exclusive", 32'(valid) + 32'(frame_err) + 32'(parity_err), 1);
      kind = valid ? EV_VALID : (frame_err ? EV_FRAME : EV_PARITY);
      if (valid) begin
        n_valid++;
        valid_cyc = cyc;
      end
      if (frame_err) n_frame++;
      if (parity_err) n_parity++;
      check_eq("event_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("event_kind", kind, e.kind);
        if (valid) check_eq("rx_byte", data_out, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_good);
    logic p;
    if (!stop_ok) exp_q.push_back('{EV_FRAME, b});
    else if (PAR_EN && !par_good) exp_q.push_back('{EV_PARITY, b});
    else begin
      exp_q.push_back('{EV_VALID, b});
      last_good = b;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR_EN) begin
      p = (^b) ^ PODD ^ !par_good;
      send_bit(p);
    end
    send_bit(stop_ok);
  endtask

  task automatic drain(input string tag);
    tick(2 * CPB);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_eq({tag, "_dout"}, data_out, last_good);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int v0, f0, p0, c0, lo;
    logic [7:0] msg [12];
    logic [7:0] b;
    logic s_ok, p_ok;

    msg = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20, 8'h46, 8'h50, 8'h47, 8'h41, 8'h0a};

    tick(4);
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_perr", parity_err, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    tick(CPB);

    // Single frame plus latency from the first edge that samples the start bit.
    v0 = n_valid; f0 = n_frame;
    c0 = cyc;
    send_frame(8'h48, 1'b1, 1'b1);
    tick(CPB);
    check_eq("t1_nvalid", n_valid - v0, 1);
    check_eq("t1_nferr", n_frame - f0, 0);
    check_eq("t1_latency", valid_cyc - c0 - 1, LAT);
    drain("t1");

    v0 = n_valid;
    foreach (msg[i]) send_frame(msg[i], 1'b1, 1'b1);
    check_eq("t2_nvalid", n_valid - v0, 12);
    drain("t2");

    // Short low glitch must be rejected in START.
    v0 = n_valid + n_frame + n_parity;
    data_in = 1'b0;
    tick(5);
    check_eq("t3_busy_hi", busy, 1);
    data_in = 1'b1;
    for (int i = 0; i < int'(HALF) + 3; i++) begin
      if (!busy) break;
      tick(1);
    end
    check_eq("t3_busy_lo", busy, 0);
    tick(CPB);
    check_eq("t3_no_pulse", n_valid + n_frame + n_parity - v0, 0);
    check_eq("t3_dout", data_out, last_good);

    v0 = n_valid; f0 = n_frame;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (3) send_bit(1'b0);
    send_bit(1'b1);
    check_eq("t4_nferr", n_frame - f0, 1);
    check_eq("t4_nvalid", n_valid - v0, 0);
    check_eq("t4_dout_held", data_out, last_good);
    send_frame(8'h41, 1'b1, 1'b1);
    check_eq("t4_recover", n_valid - v0, 1);
    drain("t4");

    // Reset in the middle of the data bits of 0x3C.
    v0 = n_valid + n_frame + n_parity;
    b = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_dout", data_out, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_valid", valid, 0);
    last_good = 8'h00;
    data_in = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(CPB);
    check_eq("t5_no_pulse", n_valid + n_frame + n_parity - v0, 0);
    send_frame(8'hA5, 1'b1, 1'b1);
    drain("t5");

    if (PAR_EN) begin
      v0 = n_valid; p0 = n_parity;
      send_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0);
      check_eq("t6_nvalid", n_valid - v0, 1);
      check_eq("t6_nperr", n_parity - p0, 1);
      drain("t6");
    end

    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      s_ok = ($urandom_range(0, 7) != 0);
      p_ok = ($urandom_range(0, 5) != 0);
      send_frame(b, s_ok, p_ok);
      if (!s_ok) begin
        lo = $urandom_range(0, 3);
        repeat (lo) send_bit(1'b0);
        send_bit(1'b1);
      end else if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, 20));
      end
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
